// File: rtl/sdram_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_host_arbiter
// Purpose  : Two-port req/ack arbiter in front of the single-port SDRAM
//            controller host interface. It retries commands that the
//            controller drops and routes read data back to the owning port.
// Options  : SDRAM_ARB_FIXED_PRIO_EN - port 0 always wins ties (no RR pointer)
// Revision : 1.0 - initial release
// ============================================================================
module sdram_host_arbiter #(
    parameter int HADDR_WIDTH    = 24,
    parameter int CONFIRM_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   p0_req,
    input  logic                   p0_we,
    input  logic [HADDR_WIDTH-1:0] p0_addr,
    input  logic [15:0]            p0_wdata,
    output logic                   p0_ack,
    output logic                   p0_rvalid,
    output logic [15:0]            p0_rdata,
    input  logic                   p1_req,
    input  logic                   p1_we,
    input  logic [HADDR_WIDTH-1:0] p1_addr,
    input  logic [15:0]            p1_wdata,
    output logic                   p1_ack,
    output logic                   p1_rvalid,
    output logic [15:0]            p1_rdata,
    output logic [HADDR_WIDTH-1:0] sd_wr_addr,
    output logic [HADDR_WIDTH-1:0] sd_rd_addr,
    output logic [15:0]            sd_wr_data,
    output logic                   sd_wr_enable,
    output logic                   sd_rd_enable,
    input  logic [15:0]            sd_rd_data,
    input  logic                   sd_rd_ready,
    input  logic                   sd_busy
);

    localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CONFIRM = 3'd2,
        S_WAIT_RD = 3'd3,
        S_WAIT_WR = 3'd4
    } state_t;

    state_t                 state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic                   owner_q,  owner_d;
    logic                   we_q,     we_d;
    logic [HADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [15:0]            wdata_q,  wdata_d;
    logic [1:0]             ack_q,    ack_d;
    logic [1:0]             rvalid_q, rvalid_d;
    logic [15:0]            rdata0_q, rdata0_d;
    logic [15:0]            rdata1_q, rdata1_d;
    logic                   winner;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    always_comb winner = p0_req ? 1'b0 : 1'b1;
`else
    // prio_q names the port that wins a tie; it flips away from each winner
    logic prio_q, prio_d;
    always_comb winner = (p0_req && p1_req) ? prio_q : !p0_req;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_d    = 2'b00;
        rvalid_d = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
        prio_d   = prio_q;
`endif
        case (state_q)
            S_IDLE: begin
                if ((p0_req || p1_req) && !sd_busy) begin
                    owner_d = winner;
                    we_d    = winner ? p1_we    : p0_we;
                    addr_d  = winner ? p1_addr  : p0_addr;
                    wdata_d = winner ? p1_wdata : p0_wdata;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                    prio_d  = !winner;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_CONFIRM;
            end
            S_CONFIRM: begin
                // No busy within the window means the controller was in
                // refresh/init and silently dropped the enable pulse.
                if (sd_busy) begin
                    ack_d[owner_q] = 1'b1;
                    state_d        = we_q ? S_WAIT_WR : S_WAIT_RD;
                end else if (cnt_q == CNT_W'(CONFIRM_CYCLES - 1)) begin
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_RD: begin
                if (sd_rd_ready) begin
                    if (owner_q) rdata1_d = sd_rd_data;
                    else         rdata0_d = sd_rd_data;
                    rvalid_d[owner_q] = 1'b1;
                    state_d           = S_IDLE;
                end
            end
            S_WAIT_WR: begin
                if (!sd_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack_q    <= 2'b00;
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

`ifndef SDRAM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (!rst_n) prio_q <= 1'b0;
        else        prio_q <= prio_d;
    end
`endif

    assign sd_wr_enable = (state_q == S_ISSUE) &&  we_q;
    assign sd_rd_enable = (state_q == S_ISSUE) && !we_q;
    assign sd_wr_addr   = addr_q;
    assign sd_rd_addr   = addr_q;
    assign sd_wr_data   = wdata_q;

    assign p0_ack    = ack_q[0];
    assign p1_ack    = ack_q[1];
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;

endmodule
`default_nettype wire
